lsu_axi_master: RTL and testbench

//  Parametrised load/store unit: accepts one memory request per transaction from the exec stage and runs it as a single-beat AXI4 master transaction.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_lane.sv | 54 +++++
 rtl/lsu_axi_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit AXI master.
// Size encodings, FSM state codes and alignment helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    // One strobe bit per byte covered by the access size.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        unique case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Natural alignment check on the low address bits.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [2:0] addr_lo);
        logic bad;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo[1:0];
            default: bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the load/store unit.
// Store side: lane insert + strobes; load side: extract + extend.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(LB)
) (
    input  logic [1:0]        st_size_i,
    input  logic [OFF_W-1:0]  st_off_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [LB-1:0]     wstrb_o,
    input  logic [1:0]        ld_size_i,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  logic              ld_signed_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]        st_mask;
    logic [7:0]        ld_mask;
    logic [DATA_W-1:0] ld_shift;
    logic              ld_msb;
    logic              unused_mask_bits;

    assign st_mask = size_mask(st_size_i);
    assign ld_mask = size_mask(ld_size_i);
    // Upper mask bits only matter for 64-bit data.
    assign unused_mask_bits = ^{st_mask, ld_mask};

    // Move right-justified store data into its lane, strobe that lane.
    always_comb begin
        wdata_o = st_data_i << {st_off_i, 3'b000};
        wstrb_o = st_mask[LB-1:0] << st_off_i;
    end

    // Right-justify the addressed lane, then sign/zero fill above it.
    always_comb begin
        ld_shift = rdata_i >> {ld_off_i, 3'b000};
        unique case (ld_size_i)
            SZ_B:    ld_msb = ld_shift[7];
            SZ_H:    ld_msb = ld_shift[15];
            SZ_W:    ld_msb = ld_shift[31];
            default: ld_msb = ld_shift[DATA_W-1];
        endcase
        for (int b = 0; b < LB; b++) begin
            ld_data_o[8*b +: 8] = ld_mask[b] ? ld_shift[8*b +: 8]
                                             : {8{ld_signed_i & ld_msb}};
        end
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit: one exec-stage request -> one single-beat AXI4
// transaction, with lane steering, extension and error trapping.
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [RD_W-1:0]     req_rd,
    input  logic                req_fdst,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic [RD_W-1:0]     resp_rd,
    output logic                resp_fdst,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic [7:0]          arlen,
    output logic [1:0]          arburst,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arlock,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic [7:0]          awlen,
    output logic [1:0]          awburst,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awlock,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int         LB       = DATA_W / 8;
    localparam int         OFF_W    = $clog2(LB);
    localparam logic [2:0] AXI_SIZE = 3'(OFF_W);

    logic [2:0]        state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              fdst_q, fdst_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              wvalid_q, wvalid_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LB-1:0]     wstrb_q, wstrb_d;
    logic              rvld_q, rvld_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [RD_W-1:0]   rrd_q, rrd_d;
    logic              rfdst_q, rfdst_d;

    logic [DATA_W-1:0] lane_wdata;
    logic [LB-1:0]     lane_wstrb;
    logic [DATA_W-1:0] lane_ld;
    logic [ADDR_W-1:0] req_aligned;
    logic              req_bad;
    logic              unused_bus;

    assign unused_bus = ^{rresp[0], bresp[0], rlast};

    assign req_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign req_bad = misaligned(req_size, req_addr[2:0])
                   || (req_size == SZ_D && DATA_W != 64);

    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .st_size_i   (req_size),
        .st_off_i    (req_addr[OFF_W-1:0]),
        .st_data_i   (req_wdata),
        .wdata_o     (lane_wdata),
        .wstrb_o     (lane_wstrb),
        .ld_size_i   (size_q),
        .ld_off_i    (off_q),
        .ld_signed_i (sgn_q),
        .rdata_i     (rdata),
        .ld_data_o   (lane_ld)
    );

    // Transaction sequencing and registered response generation.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        rd_d      = rd_q;
        fdst_d    = fdst_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rvld_d    = 1'b0;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        rrd_d     = rrd_q;
        rfdst_d   = rfdst_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d  = req_addr[OFF_W-1:0];
                    size_d = req_size;
                    sgn_d  = req_signed;
                    rd_d   = req_rd;
                    fdst_d = req_fdst;
                    if (req_bad) begin
                        // Error response goes out during the ERR cycle.
                        state_d = S_ERR;
                        rvld_d  = 1'b1;
                        rerr_d  = 1'b1;
                        rdata_d = '0;
                        rrd_d   = req_rd;
                        rfdst_d = req_fdst;
                    end else if (req_we) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = req_aligned;
                        wdata_d   = lane_wdata;
                        wstrb_d   = lane_wstrb;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = req_aligned;
                    end
                end
            end
            S_RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    rvld_d  = 1'b1;
                    rerr_d  = rresp[1];
                    rdata_d = rresp[1] ? '0 : lane_ld;
                    rrd_d   = rd_q;
                    rfdst_d = fdst_q;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                // AW and W retire independently, in any order.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    rvld_d  = 1'b1;
                    rerr_d  = bresp[1];
                    rdata_d = '0;
                    rrd_d   = rd_q;
                    rfdst_d = fdst_q;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            off_q     <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            rd_q      <= '0;
            fdst_q    <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rvld_q    <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            rrd_q     <= '0;
            rfdst_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            rd_q      <= rd_d;
            fdst_q    <= fdst_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rvld_q    <= rvld_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            rrd_q     <= rrd_d;
            rfdst_q   <= rfdst_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign rready     = (state_q == S_RD_DATA);
    assign bready     = (state_q == S_WR_RESP);

    assign resp_valid = rvld_q;
    assign resp_data  = rdata_q;
    assign resp_err   = rerr_q;
    assign resp_rd    = rrd_q;
    assign resp_fdst  = rfdst_q;

    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arsize     = AXI_SIZE;
    assign arlen      = 8'd0;
    assign arburst    = 2'b01;
    assign arcache    = 4'b0011;
    assign arprot     = 3'b000;
    assign arlock     = 1'b0;

    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign awsize     = AXI_SIZE;
    assign awlen      = 8'd0;
    assign awburst    = 2'b01;
    assign awcache    = 4'b0011;
    assign awprot     = 3'b000;
    assign awlock     = 1'b0;

    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wlast      = 1'b1;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed cases then random traffic,
// checked against an arithmetic model of the LSU behaviour.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [21:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        req_fdst;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fdst;
    logic        resp_err;
    logic [21:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arlock;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [21:0] awaddr;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awlock;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int vectors = 0;
    int miscompares = 0;

    lsu_axi_master #(.ADDR_W(22), .DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .req_fdst(req_fdst),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_fdst(resp_fdst),
        .resp_err(resp_err),
        .araddr(araddr), .arsize(arsize), .arlen(arlen),
        .arburst(arburst), .arcache(arcache), .arprot(arprot),
        .arlock(arlock), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen),
        .awburst(awburst), .awcache(awcache), .awprot(awprot),
        .awlock(awlock), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load result from the byte rules: pick bytes, then extend.
    function automatic logic [31:0] ref_load(input logic [1:0] sz,
        input logic sg, input int off, input logic [31:0] word);
        longint full;
        longint v;
        logic [63:0] t;
        full = longint'(1) << (8 * (1 << sz));
        v = longint'({32'b0, word}) >> (8 * off);
        v = v % full;
        if (sg && v >= full / 2) v = v - full;
        t = v;
        return t[31:0];
    endfunction

    task automatic slave_idle();
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    // One request through the DUT with a scripted slave, fully checked.
    task automatic txn(input string tag, input logic we,
        input logic [1:0] sz, input logic sg, input logic [21:0] a,
        input logic [31:0] wd, input logic [31:0] rdat,
        input logic [1:0] rsp, input int aw_dly, input int w_dly);
        int nb, off, lat, n_ar, n_aw, n_w, aw_wait, w_wait;
        bit bad, exp_err, got, busy;
        bit ar_done, r_done, aw_done, w_done, b_done;
        logic [4:0] rd;
        logic fd;
        logic [31:0] exp_data, g_data, g_wdata;
        logic [21:0] g_araddr, g_awaddr;
        logic [2:0] g_arsize;
        logic [3:0] g_wstrb, exp_strb;
        logic g_err, g_fd;
        logic [4:0] g_rd;
        nb = 1 << sz;
        off = int'(a % 4);
        bad = (sz == 2'b11) || ((a % nb) != 0);
        exp_err = bad || rsp[1];
        exp_data = (exp_err || we) ? 32'h0 : ref_load(sz, sg, off, rdat);
        exp_strb = 4'(((1 << nb) - 1) << off);
        rd = 5'($urandom);
        fd = 1'($urandom);
        lat = 0; n_ar = 0; n_aw = 0; n_w = 0; aw_wait = 0; w_wait = 0;
        got = 0; busy = 0;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
        g_data = 0; g_wdata = 0; g_araddr = 0; g_awaddr = 0;
        g_arsize = 0; g_wstrb = 0; g_err = 0; g_fd = 0; g_rd = 0;
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_rd = rd; req_fdst = fd;
        chk({tag, ":req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 0;
        req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = 22'($urandom); req_wdata = $urandom;
        req_rd = 5'($urandom); req_fdst = 1'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) begin
                got = 1; lat = k + 1;
                g_data = resp_data; g_err = resp_err;
                g_rd = resp_rd; g_fd = resp_fdst;
                busy = arvalid | awvalid | wvalid;
                break;
            end
            if (ar_done && !r_done) begin
                rvalid = 1; rdata = rdat; rresp = rsp;
                if (rready) r_done = 1;
            end else begin
                rvalid = 0;
            end
            if (arvalid) begin
                arready = 1; ar_done = 1; n_ar++;
                g_araddr = araddr; g_arsize = arsize;
            end else begin
                arready = 0;
            end
            if (aw_done && w_done && !b_done) begin
                bvalid = 1; bresp = rsp;
                if (bready) b_done = 1;
            end else begin
                bvalid = 0;
            end
            awready = 0;
            if (awvalid && !aw_done) begin
                if (aw_wait >= aw_dly) begin
                    awready = 1; aw_done = 1; n_aw++;
                    g_awaddr = awaddr;
                end else aw_wait++;
            end
            wready = 0;
            if (wvalid && !w_done) begin
                if (w_wait >= w_dly) begin
                    wready = 1; w_done = 1; n_w++;
                    g_wdata = wdata; g_wstrb = wstrb;
                end else w_wait++;
            end
            @(posedge clk); #1;
        end
        slave_idle();
        chk({tag, ":resp_seen"}, 64'(got), 64'd1);
        chk({tag, ":resp_err"}, 64'(g_err), 64'(exp_err));
        chk({tag, ":resp_data"}, 64'(g_data), 64'(exp_data));
        chk({tag, ":resp_rd"}, 64'(g_rd), 64'(rd));
        chk({tag, ":resp_fdst"}, 64'(g_fd), 64'(fd));
        chk({tag, ":bus_idle"}, 64'(busy), 64'd0);
        chk({tag, ":n_ar"}, 64'(n_ar), 64'(!we && !bad));
        chk({tag, ":n_aw"}, 64'(n_aw), 64'(we && !bad));
        chk({tag, ":n_w"}, 64'(n_w), 64'(we && !bad));
        if (bad) chk({tag, ":err_lat"}, 64'(lat), 64'd1);
        if (!we && !bad) begin
            chk({tag, ":ld_lat"}, 64'(lat), 64'd3);
            chk({tag, ":araddr"}, 64'(g_araddr), 64'(a & ~22'h3));
            chk({tag, ":arsize"}, 64'(g_arsize), 64'd2);
        end
        if (we && !bad) begin
            chk({tag, ":awaddr"}, 64'(g_awaddr), 64'(a & ~22'h3));
            chk({tag, ":wstrb"}, 64'(g_wstrb), 64'(exp_strb));
            for (int i = 0; i < 4; i++) begin
                if (exp_strb[i]) begin
                    chk({tag, ":wbyte"}, 64'((g_wdata >> (8 * i)) & 32'hFF),
                        64'((wd >> (8 * (i - off))) & 32'hFF));
                end
            end
        end
        @(posedge clk); #1;
        chk({tag, ":pulse_once"}, 64'(resp_valid), 64'd0);
        chk({tag, ":ready_again"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [21:0] a;
        logic [1:0]  rsp;
        int nb;
        rst = 1; req_valid = 0; req_we = 0; req_size = 0;
        req_signed = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        req_fdst = 0;
        slave_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst:req_ready", 64'(req_ready), 64'd0);
        chk("rst:valids", 64'({arvalid, awvalid, wvalid, resp_valid}),
            64'd0);
        chk("rst:addr_data", 64'({araddr, awaddr, wdata, wstrb}), 64'd0);
        chk("rst:consts", 64'({arlen, arburst, arcache, arprot, arlock,
            wlast}), 64'({8'd0, 2'b01, 4'b0011, 3'b000, 1'b0, 1'b1}));
        rst = 0;
        #1;
        chk("post_rst:req_ready", 64'(req_ready), 64'd1);

        txn("lw", 0, 2'b10, 0, 22'h10, 0, 32'hDEADBEEF, 2'b00, 0, 0);
        txn("lb_s", 0, 2'b00, 1, 22'h13, 0, 32'h80FFFFFF, 2'b00, 0, 0);
        txn("lb_u", 0, 2'b00, 0, 22'h13, 0, 32'h80FFFFFF, 2'b00, 0, 0);
        txn("sh", 1, 2'b01, 0, 22'h06, 32'h1234, 0, 2'b00, 3, 0);
        txn("sw_mis", 1, 2'b10, 0, 22'h02, 32'h55, 0, 2'b00, 0, 0);
        txn("lw_slverr", 0, 2'b10, 0, 22'h24, 0, 32'hCAFE0001, 2'b10,
            0, 0);
        txn("lw_next", 0, 2'b10, 0, 22'h28, 0, 32'h01234567, 2'b00, 0, 0);
        txn("ld_illegal", 0, 2'b11, 0, 22'h40, 0, 32'h1, 2'b00, 0, 0);
        txn("sb_w_late", 1, 2'b00, 0, 22'h31, 32'hA5, 0, 2'b00, 0, 2);
        txn("sw_bslv", 1, 2'b10, 0, 22'h38, 32'h11223344, 0, 2'b11, 1, 1);

        // Stray R/B beats while idle must not produce a response.
        rvalid = 1; bvalid = 1; rresp = 2'b10; bresp = 2'b10;
        repeat (2) begin
            @(posedge clk); #1;
            chk("stray:resp_valid", 64'(resp_valid), 64'd0);
            chk("stray:req_ready", 64'(req_ready), 64'd1);
        end
        slave_idle();

        // Reset while a store is waiting on AW/W.
        req_valid = 1; req_we = 1; req_size = 2'b10; req_signed = 0;
        req_addr = 22'h20; req_wdata = 32'h99; req_rd = 1; req_fdst = 0;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        chk("rst_mid:awvalid_before", 64'(awvalid), 64'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("rst_mid:valids", 64'({arvalid, awvalid, wvalid}), 64'd0);
        chk("rst_mid:resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid:req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        chk("rst_mid:no_resp", 64'(resp_valid), 64'd0);
        txn("after_rst", 0, 2'b01, 1, 22'h16, 0, 32'h8001_7FFF, 2'b00,
            0, 0);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            a = 22'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~22'(nb - 1);
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3))
                                              : 2'($urandom_range(0, 1));
            txn("rand", 1'($urandom), sz, 1'($urandom), a, $urandom,
                $urandom, rsp, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
